// File: rtl/cdc_pkg.sv
// Shared defaults for the fast/slow clock-domain crossings.
`timescale 1ns/1ps
package cdc_pkg;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/slow_edge_detect.sv
// Samples slow_clk as data on fast_clk and flags its synchronized rising edge.
`timescale 1ns/1ps
module slow_edge_detect
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic fast_clk,
    input  logic reset,
    input  logic slow_clk,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            s_prev <= s_sync;
        end
    end

    assign rise = s_sync & ~s_prev;

endmodule

// File: rtl/fast_to_slow_hold.sv
// Hands fast-domain words to a slow domain, launching each just after a slow rise.
`timescale 1ns/1ps
module fast_to_slow_hold
    import cdc_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             fast_clk,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             launch,
    output logic             captured,
    output logic             overflow
);

    logic             rise;
    logic             hold_empty;
    logic [WIDTH-1:0] hold_reg;
    logic             launched;
    logic             accept;
    logic             fire;

    slow_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge (
        .fast_clk(fast_clk),
        .reset   (reset),
        .slow_clk(slow_clk),
        .rise    (rise)
    );

    // Accept needs an empty holder and fire needs a full one: never both.
    assign accept   = in_valid & hold_empty;
    assign fire     = rise & ~hold_empty;
    assign in_ready = hold_empty;

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            hold_empty <= 1'b1;
            hold_reg   <= '0;
            launched   <= 1'b0;
            data_out   <= '0;
            launch     <= 1'b0;
            captured   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            launch   <= fire;
            captured <= rise & launched;
            if (accept) begin
                hold_reg   <= in_data;
                hold_empty <= 1'b0;
            end else if (fire) begin
                hold_empty <= 1'b1;
            end
            if (fire) begin
                data_out <= hold_reg;
                launched <= 1'b1;
            end else if (rise) begin
                launched <= 1'b0;
            end
            if (in_valid & ~hold_empty) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fast_to_slow_hold.sv
// Directed bench: launch timing, capture, back-to-back, overflow and reset cases.
`timescale 1ns/1ps
module tb_fast_to_slow_hold;

    logic       fast_clk;
    logic       reset;
    logic       slow_clk;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_out;
    logic       launch;
    logic       captured;
    logic       overflow;

    logic [3:0] scnt = '0;
    logic [7:0] slow_q = '0;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [7:0] data;
        int         k;
        int         exp_w;
    } vec_t;

    vec_t tbl [5];

    fast_to_slow_hold #(
        .WIDTH(8),
        .SYNC_STAGES(2)
    ) dut (
        .fast_clk(fast_clk),
        .reset   (reset),
        .slow_clk(slow_clk),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out(data_out),
        .launch  (launch),
        .captured(captured),
        .overflow(overflow)
    );

    initial fast_clk = 1'b0;
    always #10 fast_clk = ~fast_clk;

    // slow_clk: 16 fast periods, high while scnt is 8..15
    always @(negedge fast_clk) scnt <= scnt + 4'd1;
    assign slow_clk = scnt[3];

    always @(posedge slow_clk) slow_q <= data_out;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge fast_clk);
        #1;
    endtask

    task automatic wait_phase(input int k);
        int n = 0;
        do begin
            tick();
            n++;
        end while (scnt != k[3:0] && n < 40);
        chk("phase", {28'd0, scnt}, k);
    endtask

    task automatic offer(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        chk("ready_low", in_ready, 0);
    endtask

    task automatic wait_launch(input string tag, input logic [7:0] prev,
                               input int req_w);
        int w = 0;
        while (!launch && w < 40) begin
            chk({tag, "_hold"}, data_out, prev);
            chk({tag, "_nocap"}, captured, 0);
            tick();
            w++;
        end
        chk({tag, "_lwait"}, w, req_w);
    endtask

    task automatic wait_capture(input string tag, input logic [7:0] d,
                                input int req_w);
        int w = 0;
        do begin
            tick();
            w++;
            if (!captured) begin
                chk({tag, "_dstable"}, data_out, d);
                chk({tag, "_nolaunch"}, launch, 0);
            end
        end while (!captured && w < 40);
        chk({tag, "_cwait"}, w, req_w);
    endtask

    logic [7:0] prev;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{8'hA5, 4, 6};
        tbl[1] = '{8'h5A, 9, 1};
        tbl[2] = '{8'h44, 10, 16};
        tbl[3] = '{8'h3C, 15, 11};
        tbl[4] = '{8'h01, 0, 10};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        // release reset while slow_clk is high
        wait_phase(12);
        reset = 1'b0;
        tick();
        chk("rst_ready", in_ready, 1);
        chk("rst_data", data_out, 0);
        chk("rst_launch", launch, 0);
        chk("rst_cap", captured, 0);
        chk("rst_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("rst_rise_launch", launch, 0);
            chk("rst_rise_cap", captured, 0);
        end

        prev = 8'h00;
        for (int i = 0; i < 5; i++) begin
            wait_phase(tbl[i].k);
            offer(tbl[i].data);
            wait_launch("tbl", prev, tbl[i].exp_w);
            chk("tbl_data", data_out, tbl[i].data);
            chk("tbl_ready", in_ready, 1);
            wait_capture("tbl", tbl[i].data, 16);
            chk("tbl_slow_q", slow_q, tbl[i].data);
            prev = tbl[i].data;
        end

        // back-to-back: second word accepted on the first launch cycle
        wait_phase(4);
        offer(8'h11);
        wait_launch("b2b1", prev, 6);
        chk("b2b1_data", data_out, 8'h11);
        offer(8'h22);
        wait_capture("b2b1", 8'h11, 15);
        chk("b2b_same_launch", launch, 1);
        chk("b2b_same_data", data_out, 8'h22);
        wait_capture("b2b2", 8'h22, 16);
        chk("b2b2_launch", launch, 0);
        chk("b2b2_slow_q", slow_q, 8'h22);

        // overflow: 0x33 offered while 0x66 is pending
        wait_phase(4);
        offer(8'h66);
        in_valid = 1'b1;
        in_data  = 8'h33;
        tick();
        in_valid = 1'b0;
        chk("ovf_set", overflow, 1);
        wait_launch("ovf", 8'h22, 5);
        chk("ovf_data", data_out, 8'h66);
        wait_capture("ovf", 8'h66, 16);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_slow_q", slow_q, 8'h66);

        // reset one cycle after a launch
        wait_phase(4);
        offer(8'h55);
        wait_launch("rst2", 8'h66, 6);
        chk("rst2_data", data_out, 8'h55);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst2_out", data_out, 0);
        chk("rst2_ready", in_ready, 1);
        chk("rst2_ovf", overflow, 0);
        for (int i = 0; i < 24; i++) begin
            chk("rst2_nocap", captured, 0);
            chk("rst2_nolaunch", launch, 0);
            chk("rst2_data0", data_out, 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fast_to_slow_hold.md
Name: fast_to_slow_hold

Overview:
- Carries multi-bit words from the fast_clk domain into a slower clock domain; the reverse direction of the existing slow-to-fast enable crossing.
- Runs entirely on fast_clk. slow_clk enters as a sampled data signal, is synchronized, and its rising edges are detected.
- A fast-side producer hands off words with a valid/ready handshake.
- data_out changes only just after a slow_clk rising edge, so it is stable for a full slow period before the next slow-domain capture edge.

Parameters:
- WIDTH, 8, data word width in bits.
- SYNC_STAGES, 2, number of flops synchronizing slow_clk into fast_clk (minimum 2).

Ports:
- fast_clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- slow_clk  input  1  slow-domain clock, treated as asynchronous data; no flop is clocked by it.
- in_data  input  WIDTH  word from the fast-domain producer.
- in_valid  input  1  producer offers in_data this cycle.
- in_ready  output  1  holding register empty; a word is accepted when in_valid & in_ready.
- data_out  output  WIDTH  word presented to the slow domain; held stable between launches.
- launch  output  1  one-cycle pulse when data_out is loaded with a new word.
- captured  output  1  one-cycle pulse at the slow rising edge that captures the last launched word.
- overflow  output  1  sticky; set when in_valid arrives while in_ready=0.

Behaviour:
- Synchronizer: slow_clk passes through SYNC_STAGES flops to give s_sync; s_prev registers s_sync. rise = s_sync & ~s_prev (combinational from registers).
- Holding register hold_reg with flag hold_full. in_ready = ~hold_full, driven directly from a register.
- Accept: when in_valid & in_ready, hold_reg <= in_data and hold_full <= 1 on the next edge.
- Reject: when in_valid & ~in_ready, the word is dropped and overflow <= 1. overflow clears only on reset.
- Launch: on a cycle with rise=1 and hold_full=1:
  - data_out <= hold_reg, hold_full <= 0, launched <= 1, launch pulses for 1 cycle.
  - in_ready is high on the following cycle.
- Capture: on a cycle with rise=1 and launched=1, captured pulses for 1 cycle and launched clears unless the same rise also launches a new word.
- Simultaneous events:
  - rise with launched=1 and hold_full=1 gives captured and launch on the same cycle; launched stays 1.
  - rise with hold_full=0 and an accepted word in the same cycle: the accept completes, no launch, and the word waits for the next rise.
- data_out is never modified except at a launch.
- Latency from an accepted word to launch is variable: it waits for the next detected rise.
- Detected rise trails the actual slow_clk edge by SYNC_STAGES to SYNC_STAGES+1 fast cycles.
- The slow domain captures data_out one slow period after the launch.
- Clock-ratio requirement: slow period >= 2*(SYNC_STAGES+2) fast periods, and each slow_clk phase >= SYNC_STAGES+2 fast periods. Behaviour outside this range is undefined.
- Reset applies on a fast_clk edge with reset=1. All outputs are 0 on the cycle after, except in_ready, which is 1. State after reset:
  - hold_full=0, launched=0, data_out=0, launch=0, captured=0, overflow=0.
  - Synchronizer flops and s_prev are 0, so a slow_clk already high produces one rise after reset; it launches nothing because hold_full=0.
- Reset in the middle of a transfer discards any pending or launched word, and no captured pulse follows for it.

Decomposition:
- Shared package cdc_pkg holds the default WIDTH and SYNC_STAGES constants, shared with the existing slow-to-fast crossing.
- One sub-module, slow_edge_detect: contains the SYNC_STAGES synchronizer, the s_prev register and the rise output, with ports fast_clk, reset, slow_clk, rise.
- The top level holds the holding register, the launched flag, data_out and the handshake logic.

Test Plan:
- Setup for all cases: WIDTH=8, SYNC_STAGES=2, fast 50 MHz, slow_clk period 16 fast cycles (8 high, 8 low).
- Reset with slow_clk high -> in_ready=1 and data_out=0x00 on the cycle after reset. One rise occurs with no launch pulse and no captured pulse.
- Single word 0xA5 accepted mid slow-low phase -> in_ready=0 the next cycle. launch and data_out=0xA5 come 2-3 fast cycles after the slow_clk rising edge. in_ready=1 one cycle later. captured pulses one slow period (16 fast cycles) after launch. A slow-domain register clocked by slow_clk reads 0xA5.
- Back-to-back words 0x11 then 0x22, the second accepted right after the first launch -> 0x22 launches on the next rise. captured for 0x11 and launch for 0x22 are asserted in the same cycle.
- 0x33 offered while hold_full=1 -> word dropped, overflow=1 and it stays 1. The pending word launches unchanged, and data_out never shows 0x33.
- in_valid asserted in the same cycle as a rise with hold empty (word 0x44) -> accepted with no launch that cycle. Launch happens at the following rise (about 16 cycles later), and data_out holds its previous value until then.
- Reset asserted 1 cycle after launch of 0x55 -> no captured pulse afterward. data_out=0x00 and in_ready=1 after reset.
